id_stage_ctrl: RTL and testbench

Decode-stage controller for the 5-stage RISC-V pipeline. It owns the IF/ID pipeline register and classifies the held instruction into the 3-bit immediate-format select that drives the immediate generator. It detects load-use hazards against EX and injects a one-cycle bubble, discards the ID instruction on a taken branch or jump, and keeps saturating stall and flush counters for performance monitoring.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/imm_type_dec.sv | 48 ++++
 rtl/id_stage_ctrl.sv | 99 +++++++++
 tb/tb_id_stage_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RV32 decode stage: opcode map, immediate-format
// selects, decode-controller FSM state encoding and the canonical NOP.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/imm_type_dec.sv
// Combinational opcode classifier.
//   opcode   : inst[6:0]
//   immtype  : immediate-format select (IMM_*)
//   rs1_used : instruction reads inst[19:15]
//   rs2_used : instruction reads inst[24:20]
//   illegal  : opcode outside the supported set
module imm_type_dec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] immtype,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       illegal
);

  always_comb begin
    immtype  = IMM_NONE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        immtype  = IMM_I;
        rs1_used = 1'b1;
      end
      OPC_STORE: begin
        immtype  = IMM_S;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        immtype  = IMM_B;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: immtype = IMM_U;
      OPC_JAL:            immtype = IMM_J;
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      // Unknown opcodes read no registers so they can never raise a hazard.
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: IF/ID register, immediate-format classification,
// load-use bubble insertion, branch flush and saturating event counters.
//   clk, rst                : clock, synchronous active-high reset
//   if_valid/if_inst/if_pc  : fetch word; if_ready says ID takes it
//   ex_valid/ex_memread/ex_rd : EX instruction info for load-use detection
//   branch_taken            : flush request from EX
//   id_valid/id_inst/id_pc  : issued instruction and its PC
//   id_immtype/id_illegal   : decode of the held instruction
//   stall                   : bubble inserted this cycle
//   stall_cnt/flush_cnt     : saturating performance counters
module id_stage_ctrl
  import riscv_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [2:0]       id_immtype,
  output logic             id_illegal,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [0:0]  state;
  logic        vld;
  logic [2:0]  dec_imm;
  logic        rs1_used, rs2_used, dec_ill;
  logic        hazard;
  logic [4:0]  rs1, rs2;

  imm_type_dec u_dec (
    .opcode   (id_inst[6:0]),
    .immtype  (dec_imm),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .illegal  (dec_ill)
  );

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

  // Masked in STALL: EX then holds the bubble we just inserted.
  assign hazard = (state == ST_RUN) && vld && ex_valid && ex_memread &&
                  (ex_rd != 5'd0) &&
                  ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));

  assign stall      = hazard && !branch_taken;
  assign id_valid   = vld && !stall && !branch_taken;
  assign if_ready   = !stall;
  assign id_immtype = vld ? dec_imm : IMM_NONE;
  assign id_illegal = vld && dec_ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      vld     <= 1'b0;
      id_inst <= NOP_INST;
      id_pc   <= RESET_PC;
    end else if (branch_taken) begin
      state <= ST_RUN;
      vld   <= 1'b0;
    end else if (stall) begin
      state <= ST_STALL;
    end else begin
      state <= ST_RUN;
      vld   <= if_valid;
      if (if_valid) begin
        id_inst <= if_inst;
        id_pc   <= if_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (branch_taken && vld && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_ctrl.sv
module tb_id_stage_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] ADD    = 32'h0020_81b3; // add x3,x1,x2
  localparam logic [31:0] ADD00  = 32'h0000_01b3; // add x3,x0,x0
  localparam logic [31:0] LUI    = 32'h1234_52b7; // lui x5; inst[19:15]=8
  localparam logic [31:0] ADDI7  = 32'h0070_8293; // addi x5,x1,7; inst[24:20]=7

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0, if_pc = '0;
  logic        ex_valid = 1'b0, ex_memread = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        branch_taken = 1'b0;

  logic        if_ready, id_valid, id_illegal, stall;
  logic [31:0] id_inst, id_pc;
  logic [2:0]  id_immtype;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_if_ready, s_id_valid, s_id_illegal, s_stall;
  logic [31:0] s_id_inst, s_id_pc;
  logic [2:0]  s_id_immtype;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic        ill;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  id_stage_ctrl #(.CNT_W(16), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(if_ready), .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_immtype(id_immtype), .id_illegal(id_illegal), .stall(stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_stage_ctrl #(.CNT_W(2), .RESET_PC(RST_PC)) dut_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_ready(s_if_ready), .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .id_valid(s_id_valid), .id_inst(s_id_inst),
    .id_pc(s_id_pc), .id_immtype(s_id_immtype), .id_illegal(s_id_illegal),
    .stall(s_stall), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic exv, input logic exm, input logic [4:0] rd,
                     input logic br);
    if_valid = iv; if_inst = ins; if_pc = pc;
    ex_valid = exv; ex_memread = exm; ex_rd = rd; branch_taken = br;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [2:0] imm, input logic ill);
    exp_t e;
    e.inst = ins; e.pc = pc; e.imm = imm; e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Monitor: every issued instruction must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && id_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", id_inst, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_inst", id_inst, e.inst);
        chk("issue_pc", id_pc, e.pc);
        chk("issue_immtype", {29'd0, id_immtype}, {29'd0, e.imm});
        chk("issue_illegal", {31'd0, id_illegal}, {31'd0, e.ill});
      end
    end
  end

  logic [31:0] s_inst [10];
  logic [2:0]  s_imm  [10];
  logic        s_ill  [10];

  initial begin
    s_inst[0] = 32'h0000_a283; s_imm[0] = 3'b000; s_ill[0] = 1'b0; // LOAD
    s_inst[1] = 32'h0020_a023; s_imm[1] = 3'b001; s_ill[1] = 1'b0; // STORE
    s_inst[2] = 32'h0020_8063; s_imm[2] = 3'b010; s_ill[2] = 1'b0; // BRANCH
    s_inst[3] = LUI;           s_imm[3] = 3'b011; s_ill[3] = 1'b0; // LUI
    s_inst[4] = 32'h0000_0297; s_imm[4] = 3'b011; s_ill[4] = 1'b0; // AUIPC
    s_inst[5] = 32'h0000_006f; s_imm[5] = 3'b100; s_ill[5] = 1'b0; // JAL
    s_inst[6] = ADD;           s_imm[6] = 3'b111; s_ill[6] = 1'b0; // OP
    s_inst[7] = 32'h0010_8093; s_imm[7] = 3'b000; s_ill[7] = 1'b0; // OP-IMM
    s_inst[8] = 32'h0000_80e7; s_imm[8] = 3'b000; s_ill[8] = 1'b0; // JALR
    s_inst[9] = 32'h0000_000f; s_imm[9] = 3'b111; s_ill[9] = 1'b1; // 0001111

    // Reset
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inst", id_inst, 32'h0000_0013);
    chk("rst_pc", id_pc, RST_PC);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_immtype", {29'd0, id_immtype}, 32'd7);
    chk("rst_illegal", {31'd0, id_illegal}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    tick();

    // Immediate-type stream, back to back
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, s_inst[i], 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 1'b0);
      push(s_inst[i], 32'h1000 + 32'(i * 4), s_imm[i], s_ill[i]);
      tick();
    end
    idle();
    tick(); // last word issues in this cycle
    @(negedge clk);
    chk("empty_valid", {31'd0, id_valid}, 32'd0);
    chk("empty_immtype", {29'd0, id_immtype}, 32'd7);
    chk("empty_illegal", {31'd0, id_illegal}, 32'd0);
    tick();

    // Load-use stall: EX load writes x2, ID holds add x3,x1,x2
    drv(1'b1, ADD, 32'h2000, 1'b0, 1'b0, 5'd0, 1'b0);
    push(ADD, 32'h2000, 3'b111, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
    @(negedge clk);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_id_valid", {31'd0, id_valid}, 32'd0);
    chk("lu_if_ready", {31'd0, if_ready}, 32'd0);
    tick();
    // EX inputs unchanged: detection must be masked in the STALL cycle
    @(negedge clk);
    chk("lu_after_stall", {31'd0, stall}, 32'd0);
    chk("lu_after_valid", {31'd0, id_valid}, 32'd1);
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    tick();

    // No false stalls
    drv(1'b1, ADD00, 32'h2100, 1'b0, 1'b0, 5'd0, 1'b0);
    push(ADD00, 32'h2100, 3'b111, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("nf_rd0_stall", {31'd0, stall}, 32'd0);
    tick();

    drv(1'b1, LUI, 32'h2104, 1'b0, 1'b0, 5'd0, 1'b0);
    push(LUI, 32'h2104, 3'b011, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd8, 1'b0);
    @(negedge clk);
    chk("nf_lui_stall", {31'd0, stall}, 32'd0);
    tick();

    drv(1'b1, ADDI7, 32'h2108, 1'b0, 1'b0, 5'd0, 1'b0);
    push(ADDI7, 32'h2108, 3'b000, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0);
    @(negedge clk);
    chk("nf_itype_stall", {31'd0, stall}, 32'd0);
    chk("nf_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    tick();

    // Flush beats hazard; the simultaneous fetch word is dropped
    drv(1'b1, ADD, 32'h2200, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, 32'h0000_a283, 32'h2204, 1'b1, 1'b1, 5'd2, 1'b1);
    @(negedge clk);
    chk("fl_stall", {31'd0, stall}, 32'd0);
    chk("fl_id_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("fl_held_valid", {29'd0, id_immtype}, 32'd7);
    chk("fl_inst_hold", id_inst, ADD);
    chk("fl_pc_hold", id_pc, 32'h2200);
    chk("fl_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("fl_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk("fl_sat_flush_cnt", {30'd0, s_flush_cnt}, 32'd1);
    tick();

    // Five more stalls: 16-bit counter keeps counting, 2-bit one sticks at 3
    for (int i = 1; i <= 5; i++) begin
      drv(1'b1, ADD, 32'h3000 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 1'b0);
      push(ADD, 32'h3000 + 32'(i * 4), 3'b111, 1'b0);
      tick();
      drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 1'b0);
      @(negedge clk);
      chk("sat_stall", {31'd0, stall}, 32'd1);
      tick();
      idle();
      @(negedge clk);
      chk("sat_cnt16", {16'd0, stall_cnt}, 32'(1 + i));
      chk("sat_cnt2", {30'd0, s_stall_cnt}, (1 + i) > 3 ? 32'd3 : 32'(1 + i));
      tick();
    end

    // Reset in the middle of a stall
    drv(1'b1, ADD, 32'h4000, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd2, 1'b0);
    @(negedge clk);
    chk("mr_stall", {31'd0, stall}, 32'd1);
    tick();
    rst = 1'b1;
    drv(1'b1, 32'h0000_a283, 32'h4004, 1'b1, 1'b1, 5'd2, 1'b1);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("mr_valid", {31'd0, id_valid}, 32'd0);
    chk("mr_inst", id_inst, 32'h0000_0013);
    chk("mr_pc", id_pc, RST_PC);
    chk("mr_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("mr_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("mr_stall", {31'd0, stall}, 32'd0);
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
